// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame parser: parser states,
// sync bytes and default sizing.
package uart_frame_pkg;

  typedef enum logic [2:0] {
    HUNT0       = 3'd0,
    HUNT1       = 3'd1,
    GET_LEN     = 3'd2,
    GET_PAYLOAD = 3'd3,
    GET_CSUM    = 3'd4,
    DRAIN       = 3'd5
  } state_t;

  localparam logic [7:0] SYNC0 = 8'hAA;
  localparam logic [7:0] SYNC1 = 8'h55;

  localparam int DEFAULT_MAX_PAYLOAD  = 64;
  // Two 11-bit character times at 434 clocks per bit.
  localparam int DEFAULT_TIMEOUT_CLKS = 9548;

endpackage

// File: rtl/uart_frame_parser_frame_buffer.sv
// Payload store for one frame: register array with a synchronous write
// port and an asynchronous read port.
module frame_buffer #(
  parameter int DEPTH = 64,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  // NOTE: the array is deliberately not reset; every location is written by
  // the current frame before DRAIN can read it, and a reset would turn the
  // storage into a much larger flop bank with a reset net.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_frame_parser.sv
// Assembles AA 55 N payload checksum frames from the UART byte strobe,
// validates them and streams good payloads over a valid/ready interface.
module uart_frame_parser
  import uart_frame_pkg::*;
#(
  parameter int MAX_PAYLOAD  = DEFAULT_MAX_PAYLOAD,
  parameter int TIMEOUT_CLKS = DEFAULT_TIMEOUT_CLKS
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_RX_DV,
  input  logic [7:0] i_RX_Byte,
  output logic [7:0] o_Data,
  output logic       o_Valid,
  input  logic       i_Ready,
  output logic       o_Last,
  output logic [7:0] o_Frame_Len,
  output logic       o_Frame_OK,
  output logic       o_Err_Checksum,
  output logic       o_Err_Length,
  output logic       o_Err_Timeout,
  output logic       o_Overrun
);

  localparam int PTR_W  = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
  localparam int TCNT_W = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CLKS - 1);
  localparam logic [7:0]        MAX_LEN   = 8'(MAX_PAYLOAD);

  state_t            state;
  logic [7:0]        len;
  logic [7:0]        csum;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [TCNT_W-1:0] tcnt;

  logic       buf_we;
  logic [7:0] buf_rdata;
  logic       timed;
  logic       timer_hit;
  logic       last_wr;

  frame_buffer #(
    .DEPTH (MAX_PAYLOAD),
    .AW    (PTR_W)
  ) u_buf (
    .clk   (i_Clock),
    .we    (buf_we),
    .waddr (wr_ptr),
    .wdata (i_RX_Byte),
    .raddr (rd_ptr),
    .rdata (buf_rdata)
  );

  assign buf_we  = (state == GET_PAYLOAD) && i_RX_DV;
  assign last_wr = (8'(wr_ptr) == len - 8'd1);

  // The inter-byte timer only runs while a frame is partially received;
  // a byte landing on the terminal count wins over the timeout.
  assign timed     = state inside {HUNT1, GET_LEN, GET_PAYLOAD, GET_CSUM};
  assign timer_hit = timed && !i_RX_DV && (tcnt == TCNT_LAST);

  assign o_Valid = (state == DRAIN);
  assign o_Data  = o_Valid ? buf_rdata : 8'h00;
  assign o_Last  = o_Valid && (8'(rd_ptr) == len - 8'd1);

  // NOTE: all state below is sequential and uses non-blocking assignments so
  // every register samples the pre-edge values of its neighbours.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state          <= HUNT0;
      len            <= '0;
      csum           <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      tcnt           <= '0;
      o_Frame_Len    <= '0;
      o_Frame_OK     <= 1'b0;
      o_Err_Checksum <= 1'b0;
      o_Err_Length   <= 1'b0;
      o_Err_Timeout  <= 1'b0;
      o_Overrun      <= 1'b0;
    end else begin
      o_Frame_OK     <= 1'b0;
      o_Err_Checksum <= 1'b0;
      o_Err_Length   <= 1'b0;
      o_Err_Timeout  <= 1'b0;
      o_Overrun      <= 1'b0;

      if (i_RX_DV || !timed || timer_hit) tcnt <= '0;
      else                                tcnt <= tcnt + TCNT_W'(1);

      if (timer_hit) begin
        o_Err_Timeout <= 1'b1;
        state         <= HUNT0;
      end else begin
        case (state)
          HUNT0: begin
            if (i_RX_DV && i_RX_Byte == SYNC0) state <= HUNT1;
          end
          HUNT1: begin
            if (i_RX_DV) begin
              if (i_RX_Byte == SYNC1)      state <= GET_LEN;
              else if (i_RX_Byte != SYNC0) state <= HUNT0;
            end
          end
          GET_LEN: begin
            if (i_RX_DV) begin
              if (i_RX_Byte == 8'd0 || i_RX_Byte > MAX_LEN) begin
                o_Err_Length <= 1'b1;
                state        <= HUNT0;
              end else begin
                len    <= i_RX_Byte;
                csum   <= i_RX_Byte;
                wr_ptr <= '0;
                state  <= GET_PAYLOAD;
              end
            end
          end
          GET_PAYLOAD: begin
            if (i_RX_DV) begin
              csum   <= csum + i_RX_Byte;
              wr_ptr <= wr_ptr + PTR_W'(1);
              if (last_wr) state <= GET_CSUM;
            end
          end
          GET_CSUM: begin
            if (i_RX_DV) begin
              if (i_RX_Byte == csum) begin
                o_Frame_OK  <= 1'b1;
                o_Frame_Len <= len;
                rd_ptr      <= '0;
                state       <= DRAIN;
              end else begin
                o_Err_Checksum <= 1'b1;
                state          <= HUNT0;
              end
            end
          end
          DRAIN: begin
            // Bytes arriving while the buffer drains are dropped unparsed.
            if (i_RX_DV) o_Overrun <= 1'b1;
            if (i_Ready) begin
              if (o_Last) state  <= HUNT0;
              else        rd_ptr <= rd_ptr + PTR_W'(1);
            end
          end
          default: state <= HUNT0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Randomised and directed bench for uart_frame_parser against a queue-based
// frame model evaluated once per clock.
module tb_uart_frame_parser;

  localparam int MAXP = 64;
  localparam int TO   = 300;

  typedef logic [7:0] bq_t[$];

  logic       i_Clock   = 1'b0;
  logic       i_Reset   = 1'b1;
  logic       i_RX_DV   = 1'b0;
  logic [7:0] i_RX_Byte = 8'h00;
  logic       i_Ready   = 1'b0;
  logic [7:0] o_Data;
  logic       o_Valid;
  logic       o_Last;
  logic [7:0] o_Frame_Len;
  logic       o_Frame_OK;
  logic       o_Err_Checksum;
  logic       o_Err_Length;
  logic       o_Err_Timeout;
  logic       o_Overrun;

  uart_frame_parser #(
    .MAX_PAYLOAD  (MAXP),
    .TIMEOUT_CLKS (TO)
  ) dut (
    .i_Clock        (i_Clock),
    .i_Reset        (i_Reset),
    .i_RX_DV        (i_RX_DV),
    .i_RX_Byte      (i_RX_Byte),
    .o_Data         (o_Data),
    .o_Valid        (o_Valid),
    .i_Ready        (i_Ready),
    .o_Last         (o_Last),
    .o_Frame_Len    (o_Frame_Len),
    .o_Frame_OK     (o_Frame_OK),
    .o_Err_Checksum (o_Err_Checksum),
    .o_Err_Length   (o_Err_Length),
    .o_Err_Timeout  (o_Err_Timeout),
    .o_Overrun      (o_Overrun)
  );

  always #5 i_Clock = ~i_Clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- frame model ----------------
  bit         m_aa, m_frame;
  bq_t        m_body;   // length byte followed by payload received so far
  bq_t        m_out;    // payload bytes still to be delivered
  int         m_idle;
  bit         e_ok, e_cs, e_len, e_to, e_ovr;
  logic [7:0] e_flen;

  function automatic void model_reset();
    m_aa = 0; m_frame = 0; m_body.delete(); m_out.delete(); m_idle = 0;
    e_ok = 0; e_cs = 0; e_len = 0; e_to = 0; e_ovr = 0; e_flen = 8'h00;
  endfunction

  function automatic void model_parse(input logic [7:0] b);
    int s;
    if (m_frame) begin
      if (m_body.size() == 0) begin
        if (b == 0 || b > MAXP) begin e_len = 1; m_frame = 0; end
        else m_body.push_back(b);
      end else if (m_body.size() < int'(m_body[0]) + 1) begin
        m_body.push_back(b);
      end else begin
        s = 0;
        foreach (m_body[i]) s += int'(m_body[i]);
        if (8'(s) == b) begin
          e_ok = 1; e_flen = m_body[0];
          for (int i = 1; i < m_body.size(); i++) m_out.push_back(m_body[i]);
        end else e_cs = 1;
        m_frame = 0; m_body.delete();
      end
    end else if (m_aa) begin
      if (b == 8'h55) begin m_aa = 0; m_frame = 1; end
      else if (b != 8'hAA) m_aa = 0;
    end else if (b == 8'hAA) m_aa = 1;
  endfunction

  function automatic void model_step(input logic dv, input logic [7:0] b, input logic rdy);
    bit draining;
    e_ok = 0; e_cs = 0; e_len = 0; e_to = 0; e_ovr = 0;
    draining = (m_out.size() != 0);
    if (draining && rdy) void'(m_out.pop_front());
    if (dv) begin
      m_idle = 0;
      if (draining) e_ovr = 1;
      else model_parse(b);
    end else if (m_aa || m_frame) begin
      m_idle++;
      if (m_idle == TO) begin
        e_to = 1; m_aa = 0; m_frame = 0; m_body.delete(); m_idle = 0;
      end
    end else m_idle = 0;
  endfunction

  // ---------------- compare and monitor ----------------
  int         cyc = 0, dv_cyc = 0, to_cyc = 0;
  int         n_ok = 0, n_cs = 0, n_len = 0, n_to = 0, n_ovr = 0;
  bq_t        got_q;
  int         xfer_cyc[$];
  logic [7:0] last_byte = 8'h00;
  logic       prev_hold = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always @(negedge i_Clock) begin
    cyc++;
    if (i_Reset) begin
      check("reset_outputs",
            {o_Valid, o_Last, o_Frame_OK, o_Err_Checksum, o_Err_Length, o_Err_Timeout,
             o_Overrun, o_Data, o_Frame_Len}, 32'h0);
      model_reset();
      prev_hold = 1'b0;
    end else begin
      check("valid", o_Valid, m_out.size() != 0);
      if (m_out.size() != 0) begin
        check("data", o_Data, m_out[0]);
        check("last", o_Last, m_out.size() == 1);
      end
      check("frame_len", o_Frame_Len, e_flen);
      check("pulses ok/cs/len/to/ovr",
            {o_Frame_OK, o_Err_Checksum, o_Err_Length, o_Err_Timeout, o_Overrun},
            {e_ok, e_cs, e_len, e_to, e_ovr});
      if (prev_hold && o_Valid) check("data_hold", o_Data, prev_data);
      prev_hold = o_Valid && !i_Ready;
      prev_data = o_Data;
      if (o_Frame_OK)     n_ok++;
      if (o_Err_Checksum) n_cs++;
      if (o_Err_Length)   n_len++;
      if (o_Overrun)      n_ovr++;
      if (o_Err_Timeout) begin n_to++; to_cyc = cyc; end
      if (o_Valid && i_Ready) begin
        got_q.push_back(o_Data);
        xfer_cyc.push_back(cyc);
        if (o_Last) last_byte = o_Data;
      end
      if (i_RX_DV) dv_cyc = cyc;
      model_step(i_RX_DV, i_RX_Byte, i_Ready);
    end
  end

  // ---------------- drivers ----------------
  int ready_mode = 0;  // 0 always ready, 1 toggle, 2 random, 3 stalled

  always @(posedge i_Clock) begin
    #1;
    case (ready_mode)
      0:       i_Ready = 1'b1;
      1:       i_Ready = ~i_Ready;
      2:       i_Ready = 1'($urandom_range(0, 1));
      default: i_Ready = 1'b0;
    endcase
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge i_Clock); #1; end
  endtask

  task automatic send(input logic [7:0] b);
    i_RX_DV = 1'b1; i_RX_Byte = b;
    @(posedge i_Clock); #1;
    i_RX_DV = 1'b0;
  endtask

  task automatic send_frame(input bq_t bytes, input int gap);
    foreach (bytes[i]) begin send(bytes[i]); idle(gap); end
  endtask

  task automatic wait_drained(input string name, input int budget);
    int n = 0;
    while (m_out.size() != 0 && n < budget) begin idle(1); n++; end
    check({name, "_drain_in_budget"}, n >= budget, 1'b0);
    idle(2);
  endtask

  task automatic expect_got(input string name, input bq_t exp);
    check({name, "_count"}, got_q.size(), exp.size());
    foreach (exp[i]) if (i < got_q.size()) check($sformatf("%s[%0d]", name, i), got_q[i], exp[i]);
  endtask

  function automatic bq_t good_frame(input bq_t pl);
    bq_t q;
    int  s;
    s = pl.size();
    q = '{8'hAA, 8'h55, 8'(pl.size())};
    foreach (pl[i]) begin q.push_back(pl[i]); s += int'(pl[i]); end
    q.push_back(8'(s));
    return q;
  endfunction

  initial begin
    #(2_000_000);
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t f, pl;
    int  b_ok, b_cs, b_len, b_to, b_ovr, kind, gap, cut;

    repeat (3) @(posedge i_Clock);
    #3 i_Reset = 1'b0;
    @(posedge i_Clock); #1;
    check("after_reset_valid", o_Valid, 1'b0);
    check("after_reset_len", o_Frame_Len, 8'h00);

    // Good frame, consumer always ready.
    got_q.delete(); xfer_cyc.delete(); b_ok = n_ok;
    f = '{8'hAA, 8'h55, 8'h03, 8'h01, 8'h02, 8'h03, 8'h09};
    send_frame(f, 0);
    wait_drained("good1", 100);
    expect_got("good1", '{8'h01, 8'h02, 8'h03});
    check("good1_ok_pulses", n_ok - b_ok, 1);
    check("good1_frame_len", o_Frame_Len, 8'h03);
    check("good1_last_byte", last_byte, 8'h03);
    if (xfer_cyc.size() == 3) check("good1_back_to_back", xfer_cyc[2] - xfer_cyc[0], 2);

    // Checksum error, then a good frame.
    got_q.delete(); b_cs = n_cs; b_ok = n_ok;
    send_frame('{8'hAA, 8'h55, 8'h02, 8'h10, 8'h20, 8'h31}, 1);
    idle(3);
    check("csum_err_pulses", n_cs - b_cs, 1);
    check("csum_err_no_data", got_q.size(), 0);
    send_frame('{8'hAA, 8'h55, 8'h02, 8'h10, 8'h20, 8'h32}, 1);
    wait_drained("after_csum", 100);
    expect_got("after_csum", '{8'h10, 8'h20});
    check("after_csum_ok", n_ok - b_ok, 1);

    // Length errors and resync on repeated AA.
    got_q.delete(); b_len = n_len;
    send_frame('{8'hAA, 8'h55, 8'h00}, 0);
    send_frame('{8'hAA, 8'h55, 8'h41}, 0);
    idle(3);
    check("len_err_pulses", n_len - b_len, 2);
    send_frame('{8'hAA, 8'hAA, 8'h55, 8'h01, 8'h7F, 8'h80}, 0);
    wait_drained("resync", 100);
    expect_got("resync", '{8'h7F});

    // Backpressure with ready toggling every clock.
    got_q.delete(); ready_mode = 1;
    send_frame('{8'hAA, 8'h55, 8'h04, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hEE}, 0);
    wait_drained("backpressure", 200);
    expect_got("backpressure", '{8'hA1, 8'hB2, 8'hC3, 8'hD4});
    ready_mode = 0;

    // Timeout mid-payload: pulse lands TO edges after the capturing edge.
    got_q.delete(); b_to = n_to;
    send_frame('{8'hAA, 8'h55, 8'h05, 8'h11}, 0);
    idle(TO + 5);
    check("timeout_pulses", n_to - b_to, 1);
    check("timeout_distance", to_cyc - dv_cyc, TO + 1);
    send_frame('{8'hAA, 8'h55, 8'h01}, 0);
    idle(TO - 1);  // next byte coincides with the terminal count
    send_frame('{8'h42, 8'h43}, 0);
    wait_drained("byte_beats_timeout", 100);
    check("no_timeout_at_terminal", n_to - b_to, 1);
    expect_got("byte_beats_timeout", '{8'h42});

    // Overrun while stalled; drain must still complete intact.
    got_q.delete(); b_ovr = n_ovr; ready_mode = 3;
    send_frame('{8'hAA, 8'h55, 8'h02, 8'h5A, 8'hA5, 8'h01}, 0);
    idle(3);
    send(8'h33);
    idle(2);
    check("overrun_pulses", n_ovr - b_ovr, 1);
    ready_mode = 0;
    wait_drained("overrun", 100);
    expect_got("overrun", '{8'h5A, 8'hA5});

    // Asynchronous reset in the middle of a payload.
    send_frame('{8'hAA, 8'h55, 8'h05, 8'h01, 8'h02}, 1);
    #2 i_Reset = 1'b1;
    #1;
    check("async_reset_outputs",
          {o_Valid, o_Last, o_Frame_OK, o_Err_Checksum, o_Err_Length, o_Err_Timeout,
           o_Overrun, o_Data, o_Frame_Len}, 32'h0);
    repeat (2) @(posedge i_Clock);
    #3 i_Reset = 1'b0;
    @(posedge i_Clock); #1;
    got_q.delete(); b_ok = n_ok;
    send_frame('{8'hAA, 8'h55, 8'h01, 8'h66, 8'h67}, 0);
    wait_drained("after_reset", 100);
    expect_got("after_reset", '{8'h66});
    check("after_reset_ok", n_ok - b_ok, 1);

    // Randomised traffic checked cycle by cycle against the model.
    for (int fr = 0; fr < 150; fr++) begin
      ready_mode = $urandom_range(0, 2);
      kind = $urandom_range(0, 9);
      gap  = $urandom_range(0, 3);
      pl.delete();
      for (int i = 0; i < ((kind == 0) ? $urandom_range(1, MAXP) : $urandom_range(1, 8)); i++)
        pl.push_back(8'($urandom_range(0, 255)));
      f = good_frame(pl);
      case (kind)
        5: f[f.size() - 1] = f[f.size() - 1] + 8'($urandom_range(1, 255));
        6: f = '{8'hAA, 8'h55, (($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAXP + 1, 255)))};
        7: begin
          f.delete();
          for (int i = 0; i < $urandom_range(1, 5); i++)
            f.push_back(($urandom_range(0, 2) == 0) ? 8'hAA : 8'($urandom_range(0, 255)));
        end
        9: f.push_front(8'hAA);
        default: ;
      endcase
      if (kind == 8) begin
        cut = $urandom_range(1, f.size() - 1);
        foreach (f[i]) begin
          send(f[i]);
          idle((i == cut - 1) ? TO - 2 + $urandom_range(0, 3) : gap);
        end
      end else send_frame(f, gap);
      if ($urandom_range(0, 3) != 0) wait_drained("random", 3000);
      else idle($urandom_range(0, 3));
    end
    ready_mode = 0;
    idle(TO + 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
